// File: rtl/piezo_pkg.sv
// Shared types and default constants for the piezo note player.
package piezo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned PIEZO_TICK_DIV = 500000;
    localparam int unsigned PIEZO_PER_W    = 15;
    localparam int unsigned PIEZO_DUR_W    = 8;

    // Default-width note record; the top redeclares it at its own PER_W/DUR_W.
    typedef struct packed {
        logic [PIEZO_PER_W-1:0] per;
        logic [PIEZO_DUR_W-1:0] dur;
    } note_t;

endpackage

// File: rtl/piezo_note_fifo.sv
// Show-ahead note queue with registered full/empty flags and synchronous flush.
module piezo_note_fifo #(
    parameter int unsigned WIDTH = 23,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd) begin
            count_nxt = count + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/piezo_note_player.sv
// Queued square-wave note player for the piezo driver.
// Define PIEZO_GAP_EN to insert GAP_TICKS silent ticks between queued notes.
module piezo_note_player
    import piezo_pkg::*;
#(
    parameter int unsigned PER_W       = PIEZO_PER_W,
    parameter int unsigned DUR_W       = PIEZO_DUR_W,
    parameter int unsigned TICK_DIV    = PIEZO_TICK_DIV,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned GAP_TICKS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_vld,
    input  logic [PER_W-1:0] note_per,
    input  logic [DUR_W-1:0] note_dur,
    output logic             note_rdy,
    input  logic             abort,
    output logic             piezo,
    output logic             piezo_n,
    output logic             busy,
    output logic             note_done
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NOTE_W = PER_W + DUR_W;

    typedef struct packed {
        logic [PER_W-1:0] per;
        logic [DUR_W-1:0] dur;
    } note_rec_t;

    state_t            state;
    note_rec_t         head;
    note_rec_t         push_rec;
    logic [PER_W-1:0]  cur_per;
    logic [PER_W-1:0]  per_cnt;
    logic [DUR_W-1:0]  cur_dur;
    logic [DUR_W-1:0]  dur_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              tick;
    logic              note_end;

    assign push_rec  = '{per: note_per, dur: note_dur};
    assign note_rdy  = !full;
    assign push      = note_vld && !full && !abort;
    assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign note_end  = (state == PLAY) &&
                       ((cur_dur == '0) || (tick && (dur_cnt == cur_dur - 1'b1)));
    assign note_done = note_end && !abort;
    assign busy      = (state != IDLE) || !empty;

`ifdef PIEZO_GAP_EN
    localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_end;

    assign gap_end = (state == GAP) && tick && (gap_cnt == GAP_W'(GAP_TICKS - 1));
    assign pop     = !abort && !empty && ((state == IDLE) || gap_end);
`else
    logic unused_gap_ticks;
    assign unused_gap_ticks = |GAP_TICKS;
    assign pop = !abort && !empty && ((state == IDLE) || note_end);
`endif

    piezo_note_fifo #(
        .WIDTH (NOTE_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort),
        .wr_en   (push),
        .wr_data (push_rec),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // piezo doubles as the phase register; it is held at 0 whenever no tone is driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || abort) begin
            state    <= IDLE;
            cur_per  <= '0;
            cur_dur  <= '0;
            per_cnt  <= '0;
            dur_cnt  <= '0;
            tick_cnt <= '0;
            piezo    <= 1'b0;
            piezo_n  <= 1'b0;
`ifdef PIEZO_GAP_EN
            gap_cnt  <= '0;
`endif
        end else if (pop) begin
            state    <= PLAY;
            cur_per  <= head.per;
            cur_dur  <= head.dur;
            per_cnt  <= '0;
            dur_cnt  <= '0;
            tick_cnt <= '0;
            piezo    <= 1'b0;
            piezo_n  <= (head.per != '0);
`ifdef PIEZO_GAP_EN
            gap_cnt  <= '0;
`endif
        end else if (note_end) begin
`ifdef PIEZO_GAP_EN
            state    <= empty ? IDLE : GAP;
            gap_cnt  <= '0;
`else
            state    <= IDLE;
`endif
            per_cnt  <= '0;
            dur_cnt  <= '0;
            tick_cnt <= '0;
            piezo    <= 1'b0;
            piezo_n  <= 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) dur_cnt <= dur_cnt + 1'b1;
                    if (cur_per != '0) begin
                        if (per_cnt == cur_per - 1'b1) begin
                            per_cnt <= '0;
                            piezo   <= ~piezo;
                            piezo_n <= piezo;
                        end else begin
                            per_cnt <= per_cnt + 1'b1;
                        end
                    end
                end
`ifdef PIEZO_GAP_EN
                GAP: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) gap_cnt <= gap_cnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piezo_note_player.sv
// Self-checking bench for piezo_note_player; honours PIEZO_GAP_EN when defined.
module tb_piezo_note_player;

    localparam int unsigned PER_W = 15;
    localparam int unsigned DUR_W = 8;
    localparam int unsigned TD    = 10;
    localparam int unsigned QD    = 4;
    localparam int unsigned GT    = 2;
`ifdef PIEZO_GAP_EN
    localparam int unsigned GAP_CYC = GT * TD;
`else
    localparam int unsigned GAP_CYC = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             note_vld = 1'b0;
    logic [PER_W-1:0] note_per = '0;
    logic [DUR_W-1:0] note_dur = '0;
    logic             abort = 1'b0;
    logic             note_rdy;
    logic             piezo;
    logic             piezo_n;
    logic             busy;
    logic             note_done;

    int vectors = 0;
    int miscompares = 0;

    piezo_note_player #(
        .PER_W       (PER_W),
        .DUR_W       (DUR_W),
        .TICK_DIV    (TD),
        .QUEUE_DEPTH (QD),
        .GAP_TICKS   (GT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .note_vld  (note_vld),
        .note_per  (note_per),
        .note_dur  (note_dur),
        .note_rdy  (note_rdy),
        .abort     (abort),
        .piezo     (piezo),
        .piezo_n   (piezo_n),
        .busy      (busy),
        .note_done (note_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a note is a span of dur*TD cycles indexed by t; tone phase is (t/per) odd.
    typedef struct {
        int unsigned per;
        int unsigned dur;
    } mnote_t;

    mnote_t      mq[$];
    bit          m_play = 1'b0;
    int unsigned m_per = 0;
    int unsigned m_dur = 0;
    int unsigned m_t = 0;
    int unsigned m_gap = 0;

    function automatic bit m_end();
        if (!m_play) return 1'b0;
        if (m_dur == 0) return (m_t == 0);
        return (m_t == m_dur * TD - 1);
    endfunction

    function automatic bit m_phase();
        return m_play && (m_per != 0) && (((m_t / m_per) % 2) == 1);
    endfunction

    function automatic void m_start();
        mnote_t n;
        n = mq.pop_front();
        m_play = 1'b1;
        m_per  = n.per;
        m_dur  = n.dur;
        m_t    = 0;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (rst || abort) begin
            mq.delete();
            m_play = 1'b0;
            m_gap  = 0;
            m_t    = 0;
        end else begin
            acc = note_vld && (mq.size() < QD);
            if (m_gap != 0) begin
                if (m_gap == 1) begin
                    m_gap = 0;
                    m_start();
                end else begin
                    m_gap--;
                end
            end else if (!m_play) begin
                if (mq.size() != 0) m_start();
            end else if (m_end()) begin
                if (mq.size() == 0) begin
                    m_play = 1'b0;
                end else if (GAP_CYC != 0) begin
                    m_play = 1'b0;
                    m_gap  = GAP_CYC;
                end else begin
                    m_start();
                end
            end else begin
                m_t++;
            end
            if (acc) mq.push_back('{int'(note_per), int'(note_dur)});
        end
    end

    // Every cycle: {piezo, piezo_n, busy, note_done, note_rdy} against the model.
    always @(negedge clk) begin
        logic [4:0] exp_v;
        logic [4:0] act_v;
        if (rst) begin
            exp_v = 5'b00001;
        end else begin
            exp_v = {m_phase(),
                     m_play && (m_per != 0) && !m_phase(),
                     m_play || (m_gap != 0) || (mq.size() != 0),
                     m_end() && !abort,
                     mq.size() < QD};
        end
        act_v = {piezo, piezo_n, busy, note_done, note_rdy};
        check("cycle_outputs", 32'(act_v), 32'(exp_v));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_note(input int unsigned p, input int unsigned d, output int unsigned waited);
        bit accepted;
        note_per = PER_W'(p);
        note_dur = DUR_W'(d);
        note_vld = 1'b1;
        waited = 0;
        accepted = 1'b0;
        for (int i = 0; i < 400 && !accepted; i++) begin
            accepted = note_rdy;
            if (!accepted) waited++;
            step();
        end
        note_vld = 1'b0;
        if (!accepted) check("push_timeout_accepted", 0, 1);
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        check("wait_idle_busy", 32'(busy), 0);
    endtask

    typedef struct {
        int unsigned per;
        int unsigned dur;
        int unsigned exp_done;
        int unsigned exp_rises;
        int unsigned exp_first;
    } vec_t;

    vec_t vt[7];

    initial begin
        int unsigned w;
        int unsigned n_immediate;
        int unsigned d1;
        int unsigned d2;
        logic        pn12;

        // Latencies counted in negedges after the push edge; PLAY t=0 is sample 2.
        vt[0] = '{4, 3, 31, 4, 6};
        vt[1] = '{0, 2, 21, 0, 0};
        vt[2] = '{5, 0, 2, 0, 0};
        vt[3] = '{1, 1, 11, 5, 3};
        vt[4] = '{3, 2, 21, 3, 5};
        vt[5] = '{10, 1, 11, 0, 0};
        vt[6] = '{7, 4, 41, 3, 9};

        step();
        step();
        check("reset_rdy", 32'(note_rdy), 1);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            int unsigned done_at;
            int unsigned rises;
            int unsigned first;
            logic        prev;
            note_per = PER_W'(vt[i].per);
            note_dur = DUR_W'(vt[i].dur);
            note_vld = 1'b1;
            step();
            note_vld = 1'b0;
            done_at = 0;
            rises = 0;
            first = 0;
            prev = 1'b0;
            for (int c = 1; c <= 600 && done_at == 0; c++) begin
                @(negedge clk);
                if (piezo && !prev) begin
                    rises++;
                    if (first == 0) first = c;
                end
                prev = piezo;
                if (note_done) done_at = c;
                step();
            end
            check("table_done_latency", done_at, vt[i].exp_done);
            check("table_rises", rises, vt[i].exp_rises);
            check("table_first_rise", first, vt[i].exp_first);
            check("table_idle_after", 32'(busy), 0);
            step();
        end

        // Back-to-back: second note begins the cycle after the first note_done.
        note_per = PER_W'(2);
        note_dur = DUR_W'(1);
        note_vld = 1'b1;
        step();
        note_per = PER_W'(3);
        d1 = 0;
        d2 = 0;
        pn12 = 1'b0;
        for (int c = 1; c <= 200 && d2 == 0; c++) begin
            @(negedge clk);
            if (note_done) begin
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
            if (c == 12) pn12 = piezo_n;
            step();
            if (c == 1) note_vld = 1'b0;
        end
        check("b2b_first_done", d1, 11);
        check("b2b_done_spacing", d2 - d1, 10 + GAP_CYC);
        check("b2b_second_start_piezo_n", 32'(pn12), (GAP_CYC == 0) ? 1 : 0);
        wait_idle(200);

        // Queue full: five accepted at once, the sixth waits for the first pop.
        n_immediate = 0;
        for (int j = 0; j < 5; j++) begin
            push_note(2 + j, 1, w);
            if (w == 0) n_immediate++;
        end
        check("full_immediate_accepts", n_immediate, 5);
        check("full_rdy_low", 32'(note_rdy), 0);
        push_note(6, 1, w);
        check("full_sixth_wait", w, 7 + GAP_CYC);
        wait_idle(600);

        // Abort mid-note with two notes still queued; a same-cycle push is dropped.
        push_note(3, 5, w);
        push_note(3, 5, w);
        push_note(3, 5, w);
        for (int k = 0; k < 15; k++) step();
        abort = 1'b1;
        note_vld = 1'b1;
        note_per = PER_W'(4);
        note_dur = DUR_W'(2);
        @(negedge clk);
        check("abort_no_done", 32'(note_done), 0);
        step();
        abort = 1'b0;
        note_vld = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_piezo", 32'({piezo, piezo_n}), 0);
        check("abort_rdy", 32'(note_rdy), 1);
        step();
        step();
        check("abort_push_dropped", 32'(busy), 0);

        // Asynchronous reset mid-note.
        push_note(2, 4, w);
        for (int k = 0; k < 7; k++) step();
        check("pre_reset_driving", 32'(piezo | piezo_n), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({piezo, piezo_n, busy, note_done, note_rdy}), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("post_reset_idle", 32'(busy), 0);

        // Randomised traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            note_vld = ($urandom_range(0, 2) == 0);
            note_per = PER_W'($urandom_range(0, 6));
            note_dur = DUR_W'($urandom_range(0, 3));
            abort    = ($urandom_range(0, 59) == 0);
            step();
        end
        note_vld = 1'b0;
        abort = 1'b0;
        wait_idle(1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/piezo_note_player.md
# piezo_note_player

Parametrised note-sequencing tone generator for the piezo driver. It accepts notes (half-period plus duration) over a valid/ready handshake into a small queue. It plays them back-to-back, generating the square-wave period, the 1/100 s duration tick and the note-over event internally. It sits between the game/UI control logic and the piezo output pins, replacing per-note manual clear/enable sequencing with a self-running queue.

## Interface
Parameters:
- `PER_W`, 15: width of half-period field in clk cycles.
- `DUR_W`, 8: width of duration field in 1/100 s ticks.
- `TICK_DIV`, 500000: clk cycles per duration tick (50 MHz → 10 ms).
- `QUEUE_DEPTH`, 4: note queue entries; power of 2, ≥2.
- `GAP_TICKS`, 2: silent ticks between notes (used only with `PIEZO_GAP_EN`).

Ports:
- `clk`, in, 1: 50 MHz clock. One clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `note_vld`, in, 1: note offered.
- `note_per`, in, PER_W: half-period in cycles; 0 = rest.
- `note_dur`, in, DUR_W: duration in ticks; 0 = empty note.
- `note_rdy`, out, 1: queue can accept; equals !full.
- `abort`, in, 1: synchronous flush of queue and current note.
- `piezo`, out, 1: tone drive.
- `piezo_n`, out, 1: complementary drive.
- `busy`, out, 1: state ≠ IDLE or queue non-empty.
- `note_done`, out, 1: one-cycle pulse per completed note.

## Operation
- **Reset values:**
  - `piezo`, `piezo_n`, `busy`, `note_done` = 0.
  - `note_rdy` = 1.
  - Queue empty; state IDLE; all counters 0.
- **Push:** `note_vld && note_rdy` writes {per, dur} at the clock edge. `note_vld` with `note_rdy`=0 is ignored; the source holds it.
- **FSM states:** IDLE, PLAY, GAP (GAP exists only with the macro).
  - IDLE → PLAY: when the queue is non-empty. Pop the head into `cur_per`/`cur_dur`, clear all counters.
  - PLAY, period counter `per_cnt`: counts 0..cur_per-1. At cur_per-1 it toggles the internal phase and wraps to 0. If `cur_per`=0, phase is held at 0 (rest).
  - PLAY, tick counter `tick_cnt`: counts 0..TICK_DIV-1 and wraps. The wrap cycle is a tick.
  - PLAY, duration counter `dur_cnt`: increments on each tick.
  - Note end: the tick on which `dur_cnt`==cur_dur-1. The note therefore lasts exactly cur_dur×TICK_DIV cycles. `note_done` pulses on that cycle.
  - Note end, queue non-empty (no gap): pop in the same cycle, stay in PLAY, clear all counters. No dead cycle between notes.
  - Note end, queue empty: go to IDLE.
  - `cur_dur`=0 on load: `note_done` pulses on the first PLAY cycle, with no toggle. Then pop-next or IDLE.
- **Output drive:**
  - In PLAY with `cur_per`≠0: `piezo`=phase, `piezo_n`=~phase.
  - Otherwise both outputs are 0, including rest, GAP and IDLE.
  - Phase restarts at 0 for every note.
- **abort:** highest priority.
  - Next edge: state IDLE, queue emptied, counters cleared.
  - No `note_done`; a push in the same cycle is dropped.
- **Precedence:** rst > abort > note end > push.
- **Simultaneous push and pop:** when not full, both occur; occupancy is unchanged. When full, `note_rdy`=0, so only the pop occurs. `note_rdy` rises the cycle after the pop.
- **Arithmetic:** counters are unsigned and sized to their compare value (`$clog2(TICK_DIV)` bits for `tick_cnt`). No overflow is possible.

## Timing
- Push at edge N → head visible after N → popped and PLAY at edge N+1.
- The first `piezo` rise is cur_per cycles after entering PLAY.
- `note_done` is a combinational decode of registered state, so it is glitch-free and asserted for exactly one cycle.
- `note_rdy` is derived from the registered full flag, with no combinational path from `note_vld`.
- Reset asserted mid-note forces all outputs to reset values immediately (asynchronous). Play resumes only on new pushes after deassertion.

## Configuration
- `PIEZO_GAP_EN` defined:
  - At note end with a queue entry present, enter GAP. Outputs are 0 for GAP_TICKS ticks, then pop and go to PLAY.
  - At note end with the queue empty, go to IDLE. No trailing gap.
  - abort in GAP → IDLE.
- Undefined: the GAP state and its counter are not compiled. Notes are strictly back-to-back.

## Structure
- Package `piezo_pkg`:
  - `state_t` enum {IDLE, PLAY, GAP}.
  - Default constants `PIEZO_TICK_DIV`=500000 and `PIEZO_PER_W`/`PIEZO_DUR_W`.
  - Parametrised note record type {per, dur}.
- Sub-module `piezo_note_fifo`: synchronous queue with write/read pointers, full/empty and a flush input. The top level holds the FSM and counters.

## Test plan
Bench uses TICK_DIV=10, QUEUE_DEPTH=4.
- **Single note:** push per=4, dur=3 → `piezo` toggles every 4 cycles starting 4 cycles after PLAY. `note_done` pulses 30 cycles after PLAY entry. Then IDLE, `busy`=0.
- **Back-to-back:** push (per=2,dur=1) then (per=3,dur=1) → second note's phase restarts at cycle 10 with no dead cycle. Two `note_done` pulses 10 cycles apart.
- **Queue full:** six consecutive pushes → five accepted. `note_rdy`=0 from the cycle after the fifth until the cycle after the first note's end pop.
- **Edge notes:** rest per=0, dur=2 → outputs 0 for 20 cycles, then `note_done`. Empty note dur=0 → `note_done` on the first PLAY cycle, no toggle.
- **Abort:** assert `abort` mid-note with 2 queued → next cycle IDLE, `piezo`/`piezo_n`=0, `note_rdy`=1, no `note_done`.
- **Reset and gap:** `rst` mid-play → outputs at reset values asynchronously. With `PIEZO_GAP_EN` and GAP_TICKS=2, two queued dur=1 notes → 20 silent cycles between them.
